// File: rtl/rom2ram_seq.sv
// rtl/rom2ram_seq.sv - descriptor-driven flash-to-SRAM copy/fill sequencer
module rom2ram_seq #(
    parameter int                         SEGMENTS   = 2,
    parameter int                         ROM_AW     = 24,
    parameter int                         RAM_AW     = 19,
    parameter int                         LEN_W      = 17,
    parameter logic [SEGMENTS*ROM_AW-1:0] SEG_SRC    = '0,
    parameter logic [SEGMENTS*RAM_AW-1:0] SEG_DST    = '0,
    parameter logic [SEGMENTS*LEN_W-1:0]  SEG_LEN    = '0,
    parameter logic [SEGMENTS-1:0]        SEG_FILL   = '0,
    parameter logic [7:0]                 FILL_VALUE = 8'h00,
    parameter int                         WR_CYCLES  = 2,
    parameter int                         TIMEOUT    = 1023,
    parameter bit                         AUTO_START = 1'b1,
    localparam int                        IDX_W      = (SEGMENTS > 1) ? $clog2(SEGMENTS) : 1
) (
    input  logic              clk28,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [IDX_W-1:0]  seg_idx,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [7:0]        rom_data,
    input  logic              rom_valid,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    output logic              ram_wren
);

    localparam int WC_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam int TC_W = $clog2(TIMEOUT + 2);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LOAD     = 4'd1;
    localparam logic [3:0] S_ROM_REQ  = 4'd2;
    localparam logic [3:0] S_ROM_WAIT = 4'd3;
    localparam logic [3:0] S_RAM_WR   = 4'd4;
    localparam logic [3:0] S_GAP      = 4'd5;
    localparam logic [3:0] S_NEXT     = 4'd6;
    localparam logic [3:0] S_FIN      = 4'd7;
    localparam logic [3:0] S_FAIL     = 4'd8;

    logic [3:0]        state_q, state_d;
    logic [IDX_W-1:0]  seg_q, seg_d;
    logic [ROM_AW-1:0] src_q, src_d;
    logic [RAM_AW-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              fill_q, fill_d;
    logic [7:0]        dout_q, dout_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [TC_W-1:0]   tcnt_q, tcnt_d;
    logic              auto_q, auto_d;

    logic [ROM_AW-1:0] cur_src;
    logic [RAM_AW-1:0] cur_dst;
    logic [LEN_W-1:0]  cur_len;
    logic              cur_fill;
    logic [TC_W-1:0]   tcnt_nxt;
    logic              start_eff;

    always_comb begin
        cur_src  = '0;
        cur_dst  = '0;
        cur_len  = '0;
        cur_fill = 1'b0;
        for (int i = 0; i < SEGMENTS; i++) begin
            if (seg_q == IDX_W'(i)) begin
                cur_src  = SEG_SRC[i*ROM_AW +: ROM_AW];
                cur_dst  = SEG_DST[i*RAM_AW +: RAM_AW];
                cur_len  = SEG_LEN[i*LEN_W +: LEN_W];
                cur_fill = SEG_FILL[i];
            end
        end
    end

    // The pending auto-start flag is armed by reset and consumed on the first free cycle.
    assign start_eff = start | auto_q;
    // Timeout counter counts cycles since rom_rd rose, the request cycle included.
    assign tcnt_nxt  = tcnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        fill_d  = fill_q;
        dout_d  = dout_q;
        wcnt_d  = wcnt_q;
        tcnt_d  = tcnt_q;
        auto_d  = 1'b0;
        case (state_q)
            S_IDLE, S_FIN, S_FAIL: begin
                if (start_eff) begin
                    seg_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                src_d  = cur_src;
                dst_d  = cur_dst;
                rem_d  = cur_len;
                fill_d = cur_fill;
                wcnt_d = '0;
                if (cur_len == '0) begin
                    state_d = S_NEXT;
                end else if (cur_fill) begin
                    dout_d  = FILL_VALUE;
                    state_d = S_RAM_WR;
                end else begin
                    state_d = S_ROM_REQ;
                end
            end
            S_ROM_REQ: begin
                tcnt_d  = TC_W'(1);
                state_d = S_ROM_WAIT;
            end
            S_ROM_WAIT: begin
                if (rom_valid) begin
                    dout_d  = rom_data;
                    wcnt_d  = '0;
                    state_d = S_RAM_WR;
                end else if (tcnt_nxt >= TC_W'(TIMEOUT)) begin
                    state_d = S_FAIL;
                end else begin
                    tcnt_d = tcnt_nxt;
                end
            end
            S_RAM_WR: begin
                if (wcnt_q == WC_W'(WR_CYCLES - 1)) begin
                    state_d = S_GAP;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_GAP: begin
                src_d  = src_q + 1'b1;
                dst_d  = dst_q + 1'b1;
                rem_d  = rem_q - 1'b1;
                wcnt_d = '0;
                if (rem_q == LEN_W'(1)) begin
                    state_d = S_NEXT;
                end else if (fill_q) begin
                    state_d = S_RAM_WR;
                end else begin
                    state_d = S_ROM_REQ;
                end
            end
            S_NEXT: begin
                if (seg_q == IDX_W'(SEGMENTS - 1)) begin
                    state_d = S_FIN;
                end else begin
                    seg_d   = seg_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            state_q <= S_IDLE;
            seg_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            fill_q  <= 1'b0;
            dout_q  <= '0;
            wcnt_q  <= '0;
            tcnt_q  <= '0;
            auto_q  <= AUTO_START;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            fill_q  <= fill_d;
            dout_q  <= dout_d;
            wcnt_q  <= wcnt_d;
            tcnt_q  <= tcnt_d;
            auto_q  <= auto_d;
        end
    end

    // src_q is not advanced on timeout, so rom_addr keeps the failing address in FAIL.
    assign busy     = (state_q != S_IDLE) && (state_q != S_FIN) && (state_q != S_FAIL);
    assign done     = (state_q == S_FIN);
    assign error    = (state_q == S_FAIL);
    assign seg_idx  = seg_q;
    assign rom_addr = src_q;
    assign rom_rd   = (state_q == S_ROM_REQ);
    assign ram_addr = dst_q;
    assign ram_dout = dout_q;
    assign ram_wren = (state_q == S_RAM_WR);

endmodule

// File: tb/tb_rom2ram_seq.sv
// tb/tb_rom2ram_seq.sv - randomized self-checking bench for rom2ram_seq
module tb_rom2ram_seq;

    logic clk28 = 1'b0;
    always #5 clk28 = ~clk28;

    int cyc = 0;
    always @(posedge clk28) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    // Three-descriptor instance: copy, empty, wrapping fill
    logic        a_rst, a_start, a_busy, a_done, a_error;
    logic [1:0]  a_seg;
    logic [23:0] a_rom_addr;
    logic        a_rom_rd, a_rom_valid, a_ram_wren;
    logic [7:0]  a_rom_data, a_ram_dout;
    logic [18:0] a_ram_addr;

    // Single-descriptor manual-start instance with a wrapping flash range
    logic        b_rst, b_start, b_busy, b_done, b_error;
    logic [0:0]  b_seg;
    logic [23:0] b_rom_addr;
    logic        b_rom_rd, b_rom_valid, b_ram_wren;
    logic [7:0]  b_rom_data, b_ram_dout;
    logic [18:0] b_ram_addr;

    rom2ram_seq #(
        .SEGMENTS(3), .ROM_AW(24), .RAM_AW(19), .LEN_W(17),
        .SEG_SRC({24'h000000, 24'h000000, 24'h013256}),
        .SEG_DST({19'h7FFFF, 19'h00000, 19'h00010}),
        .SEG_LEN({17'd3, 17'd0, 17'd4}),
        .SEG_FILL(3'b100), .FILL_VALUE(8'hFF),
        .WR_CYCLES(2), .TIMEOUT(15), .AUTO_START(1'b1)
    ) dut_a (
        .clk28(clk28), .rst(a_rst), .start(a_start), .busy(a_busy),
        .done(a_done), .error(a_error), .seg_idx(a_seg),
        .rom_addr(a_rom_addr), .rom_rd(a_rom_rd), .rom_data(a_rom_data),
        .rom_valid(a_rom_valid), .ram_addr(a_ram_addr), .ram_dout(a_ram_dout),
        .ram_wren(a_ram_wren)
    );

    rom2ram_seq #(
        .SEGMENTS(1), .ROM_AW(24), .RAM_AW(19), .LEN_W(17),
        .SEG_SRC(24'hFFFFFE), .SEG_DST(19'h00100), .SEG_LEN(17'd3),
        .SEG_FILL(1'b0), .FILL_VALUE(8'h00),
        .WR_CYCLES(1), .TIMEOUT(1023), .AUTO_START(1'b0)
    ) dut_b (
        .clk28(clk28), .rst(b_rst), .start(b_start), .busy(b_busy),
        .done(b_done), .error(b_error), .seg_idx(b_seg),
        .rom_addr(b_rom_addr), .rom_rd(b_rom_rd), .rom_data(b_rom_data),
        .rom_valid(b_rom_valid), .ram_addr(b_ram_addr), .ram_dout(b_ram_dout),
        .ram_wren(b_ram_wren)
    );

    function automatic logic [7:0] rom_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ {a[3:0], a[23:20]} ^ 8'h5A;
    endfunction

    // Flash reader models: answer each rom_rd after k cycles unless silenced
    int a_kmin = 3, a_kmax = 3, a_silent_from = 0, a_req_n = 0, a_ksum = 0;
    int a_pend_cnt = 0, a_k = 0;
    bit a_pend = 0, a_spur = 0;
    logic [23:0] a_pend_addr;
    int b_kmin = 1, b_kmax = 1, b_req_n = 0, b_ksum = 0, b_pend_cnt = 0, b_k = 0;
    bit b_pend = 0;
    logic [23:0] b_pend_addr;

    always @(negedge clk28) begin
        a_rom_valid = 1'b0;
        if (a_rst) a_pend = 0;
        if (a_pend) begin
            a_pend_cnt--;
            if (a_pend_cnt == 0) begin
                a_rom_valid = 1'b1;
                a_rom_data  = rom_byte(a_pend_addr);
                a_pend      = 0;
            end
        end
        if (a_spur && a_ram_wren) begin
            a_rom_valid = 1'b1;
            a_rom_data  = 8'hC3;
        end
        if (a_rom_rd) begin
            a_req_n++;
            if (a_silent_from == 0 || a_req_n < a_silent_from) begin
                a_k = $urandom_range(a_kmax, a_kmin);
                a_ksum += a_k;
                a_pend = 1;
                a_pend_cnt = a_k;
                a_pend_addr = a_rom_addr;
            end
        end
    end

    always @(negedge clk28) begin
        b_rom_valid = 1'b0;
        if (b_rst) b_pend = 0;
        if (b_pend) begin
            b_pend_cnt--;
            if (b_pend_cnt == 0) begin
                b_rom_valid = 1'b1;
                b_rom_data  = rom_byte(b_pend_addr);
                b_pend      = 0;
            end
        end
        if (b_rom_rd) begin
            b_req_n++;
            b_k = $urandom_range(b_kmax, b_kmin);
            b_ksum += b_k;
            b_pend = 1;
            b_pend_cnt = b_k;
            b_pend_addr = b_rom_addr;
        end
    end

    // Bus monitors: log writes and reads, count protocol violations
    logic [31:0] aw_log[$], ar_log[$], bw_log[$], br_log[$];
    int a_seg_seq[$], a_rd_cyc[$];
    int a_busy_cyc = 0, a_viol = 0, a_fill_rd = 0, a_err_cyc = -1, a_done_rises = 0, a_wlen = 0;
    bit a_wren_prev = 0, a_busy_prev = 0, a_done_prev = 0, a_err_prev = 0;
    logic [26:0] a_wlast;
    int b_busy_cyc = 0, b_viol = 0, b_wlen = 0;
    bit b_wren_prev = 0, b_busy_prev = 0;
    logic [26:0] b_wlast;

    always @(negedge clk28) begin
        if (a_ram_wren) begin
            if (!a_wren_prev) begin
                aw_log.push_back({5'd0, a_ram_addr, a_ram_dout});
                a_wlen = 1;
            end else begin
                a_wlen++;
                if ({a_ram_addr, a_ram_dout} != a_wlast) a_viol++;
            end
        end else if (a_wren_prev && !a_rst) begin
            if (a_wlen != 2 || {a_ram_addr, a_ram_dout} != a_wlast) a_viol++;
        end
        a_wlast = {a_ram_addr, a_ram_dout};
        a_wren_prev = a_ram_wren;
        if (a_rom_rd) begin
            ar_log.push_back({8'd0, a_rom_addr});
            a_rd_cyc.push_back(cyc);
            if (a_seg == 2'd2) a_fill_rd++;
        end
        if (a_busy) begin
            a_busy_cyc++;
            if (a_seg_seq.size() == 0 || a_seg_seq[$] != int'(a_seg)) a_seg_seq.push_back(int'(a_seg));
        end
        if (a_busy_prev && !a_busy && !a_rst && !(a_done ^ a_error)) a_viol++;
        if (a_done && !a_done_prev) begin
            a_done_rises++;
            if (!a_busy_prev) a_viol++;
        end
        if (a_error && !a_err_prev) a_err_cyc = cyc;
        a_busy_prev = a_busy;
        a_done_prev = a_done;
        a_err_prev  = a_error;
    end

    always @(negedge clk28) begin
        if (b_ram_wren) begin
            if (!b_wren_prev) begin
                bw_log.push_back({5'd0, b_ram_addr, b_ram_dout});
                b_wlen = 1;
            end else begin
                b_wlen++;
                if ({b_ram_addr, b_ram_dout} != b_wlast) b_viol++;
            end
        end else if (b_wren_prev && !b_rst) begin
            if (b_wlen != 1 || {b_ram_addr, b_ram_dout} != b_wlast) b_viol++;
        end
        b_wlast = {b_ram_addr, b_ram_dout};
        b_wren_prev = b_ram_wren;
        if (b_rom_rd) br_log.push_back({8'd0, b_rom_addr});
        if (b_busy) b_busy_cyc++;
        if (b_busy_prev && !b_busy && !b_rst && !(b_done ^ b_error)) b_viol++;
        b_busy_prev = b_busy;
    end

    // Reference model: expected writes and reads from descriptor rules
    logic [31:0] em_w[$], em_r[$];

    task automatic model_seg(input logic [23:0] src, input logic [18:0] dst, input int len,
                             input bit fill, input logic [7:0] fv);
        logic [23:0] s;
        logic [18:0] d;
        for (int i = 0; i < len; i++) begin
            s = src + 24'(i);
            d = dst + 19'(i);
            em_w.push_back({5'd0, d, fill ? fv : rom_byte(s)});
            if (!fill) em_r.push_back({8'd0, s});
        end
    endtask

    task automatic model_a();
        em_w.delete();
        em_r.delete();
        model_seg(24'h013256, 19'h00010, 4, 1'b0, 8'hFF);
        model_seg(24'h000000, 19'h00000, 0, 1'b0, 8'hFF);
        model_seg(24'h000000, 19'h7FFFF, 3, 1'b1, 8'hFF);
    endtask

    task automatic model_b();
        em_w.delete();
        em_r.delete();
        model_seg(24'hFFFFFE, 19'h00100, 3, 1'b0, 8'h00);
    endtask

    function automatic int qdiff(input logic [31:0] got[$], input logic [31:0] want[$]);
        if (got.size() != want.size()) return -2;
        foreach (got[i]) if (got[i] !== want[i]) return i;
        return -1;
    endfunction

    task automatic clear_a();
        aw_log.delete(); ar_log.delete(); a_seg_seq.delete(); a_rd_cyc.delete();
        a_busy_cyc = 0; a_viol = 0; a_fill_rd = 0; a_err_cyc = -1; a_done_rises = 0;
        a_req_n = 0; a_ksum = 0; a_pend = 0;
    endtask

    task automatic clear_b();
        bw_log.delete(); br_log.delete();
        b_busy_cyc = 0; b_viol = 0; b_req_n = 0; b_ksum = 0; b_pend = 0;
    endtask

    task automatic tick();
        @(negedge clk28);
        #1;
    endtask

    task automatic pulse_a_start();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic wait_a_idle(input int budget, output bit expired);
        int n = 0;
        tick();
        while (a_busy && n < budget) begin
            tick();
            n++;
        end
        expired = a_busy;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
        repeat (3) tick();
        n_total++;
        if ({a_busy, a_done, a_error, a_seg, a_rom_addr, a_rom_rd, a_ram_addr, a_ram_dout, a_ram_wren} !== '0)
            $display("FAIL reset_a: outputs %h, want 0",
                     {a_busy, a_done, a_error, a_seg, a_rom_addr, a_rom_rd, a_ram_addr, a_ram_dout, a_ram_wren});
        else n_pass++;
        n_total++;
        if ({b_busy, b_done, b_error, b_seg, b_rom_addr, b_rom_rd, b_ram_addr, b_ram_dout, b_ram_wren} !== '0)
            $display("FAIL reset_b: outputs %h, want 0",
                     {b_busy, b_done, b_error, b_seg, b_rom_addr, b_rom_rd, b_ram_addr, b_ram_dout, b_ram_wren});
        else n_pass++;
    endtask

    task automatic test_auto_start();
        bit exp_to;
        int d;
        clear_a(); clear_b(); model_a();
        a_kmin = 3; a_kmax = 3;
        a_rst = 1'b0; b_rst = 1'b0;
        tick();
        n_total++;
        if (a_busy !== 1'b1) $display("FAIL auto_busy_rise: busy %b, want 1", a_busy);
        else n_pass++;
        wait_a_idle(500, exp_to);
        n_total++;
        if (exp_to) $display("FAIL auto_wait: busy still %b after budget, want 0", a_busy);
        else n_pass++;
        n_total++;
        if ({a_done, a_error} !== 2'b10) $display("FAIL auto_flags: done/error %b, want 10", {a_done, a_error});
        else n_pass++;
        d = qdiff(aw_log, em_w);
        n_total++;
        if (d != -1) $display("FAIL auto_writes: diff at %0d (got %0d writes, want %0d)", d, aw_log.size(), em_w.size());
        else n_pass++;
        d = qdiff(ar_log, em_r);
        n_total++;
        if (d != -1) $display("FAIL auto_reads: diff at %0d (got %0d reads, want %0d)", d, ar_log.size(), em_r.size());
        else n_pass++;
        n_total++;
        if (a_busy_cyc != 31 + a_ksum || a_ksum != 12)
            $display("FAIL auto_cycles: busy %0d cycles, want %0d (ksum %0d)", a_busy_cyc, 31 + a_ksum, a_ksum);
        else n_pass++;
        n_total++;
        if (a_seg_seq.size() != 3 || a_seg_seq[0] != 0 || a_seg_seq[1] != 1 || a_seg_seq[2] != 2)
            $display("FAIL auto_seg_seq: %0d entries, want 0,1,2", a_seg_seq.size());
        else n_pass++;
        n_total++;
        if (a_fill_rd != 0) $display("FAIL auto_fill_rd: %0d rom_rd during fill, want 0", a_fill_rd);
        else n_pass++;
        n_total++;
        if (a_viol != 0) $display("FAIL auto_protocol: %0d violations, want 0", a_viol);
        else n_pass++;
        n_total++;
        if (a_seg !== 2'd2) $display("FAIL auto_seg_final: seg_idx %0d, want 2", a_seg);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit exp_to;
        int d;
        clear_a(); model_a();
        a_kmin = 1; a_kmax = 6; a_spur = 1;
        pulse_a_start();
        n_total++;
        if ({a_busy, a_done} !== 2'b10) $display("FAIL b2b_start: busy/done %b, want 10", {a_busy, a_done});
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(6, 2)) tick();
            pulse_a_start();
        end
        wait_a_idle(500, exp_to);
        a_spur = 0;
        n_total++;
        if (exp_to) $display("FAIL b2b_wait: busy still %b after budget, want 0", a_busy);
        else n_pass++;
        d = qdiff(aw_log, em_w);
        n_total++;
        if (d != -1) $display("FAIL b2b_writes: diff at %0d (got %0d writes, want %0d)", d, aw_log.size(), em_w.size());
        else n_pass++;
        d = qdiff(ar_log, em_r);
        n_total++;
        if (d != -1) $display("FAIL b2b_reads: diff at %0d (got %0d reads, want %0d)", d, ar_log.size(), em_r.size());
        else n_pass++;
        n_total++;
        if (a_busy_cyc != 31 + a_ksum) $display("FAIL b2b_cycles: busy %0d cycles, want %0d", a_busy_cyc, 31 + a_ksum);
        else n_pass++;
        n_total++;
        if (a_done_rises != 1 || a_done !== 1'b1) $display("FAIL b2b_done: %0d done rises (done %b), want 1", a_done_rises, a_done);
        else n_pass++;
        n_total++;
        if (a_viol != 0) $display("FAIL b2b_protocol: %0d violations, want 0", a_viol);
        else n_pass++;
    endtask

    task automatic test_timeout();
        bit exp_to;
        int d;
        clear_a();
        a_kmin = 2; a_kmax = 2; a_silent_from = 2;
        pulse_a_start();
        wait_a_idle(300, exp_to);
        n_total++;
        if (exp_to) $display("FAIL to_wait: busy still %b after budget, want 0", a_busy);
        else n_pass++;
        n_total++;
        if ({a_done, a_error} !== 2'b01) $display("FAIL to_flags: done/error %b, want 01", {a_done, a_error});
        else n_pass++;
        n_total++;
        if (a_rd_cyc.size() < 2 || a_err_cyc - a_rd_cyc[1] != 15)
            $display("FAIL to_delay: error %0d cycles after second rom_rd, want 15",
                     a_rd_cyc.size() < 2 ? -1 : a_err_cyc - a_rd_cyc[1]);
        else n_pass++;
        n_total++;
        if (a_seg !== 2'd0) $display("FAIL to_seg: seg_idx %0d, want 0", a_seg);
        else n_pass++;
        n_total++;
        if (a_rom_addr !== 24'h013257) $display("FAIL to_addr: rom_addr %h, want 013257", a_rom_addr);
        else n_pass++;
        repeat (20) tick();
        n_total++;
        if (aw_log.size() != 1 || ar_log.size() != 2 || a_error !== 1'b1)
            $display("FAIL to_quiet: %0d writes %0d reads error %b, want 1 2 1", aw_log.size(), ar_log.size(), a_error);
        else n_pass++;
        a_silent_from = 0;
        clear_a(); model_a();
        pulse_a_start();
        n_total++;
        if ({a_busy, a_error} !== 2'b10) $display("FAIL to_restart: busy/error %b, want 10", {a_busy, a_error});
        else n_pass++;
        wait_a_idle(500, exp_to);
        n_total++;
        if (exp_to || {a_done, a_error} !== 2'b10)
            $display("FAIL to_rerun: done/error %b expired %b, want 10 0", {a_done, a_error}, exp_to);
        else n_pass++;
        d = qdiff(aw_log, em_w);
        n_total++;
        if (d != -1) $display("FAIL to_rerun_writes: diff at %0d (got %0d, want %0d)", d, aw_log.size(), em_w.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit exp_to;
        int n = 0;
        int d;
        clear_a();
        a_kmin = 1; a_kmax = 4;
        pulse_a_start();
        while (!(aw_log.size() == 3 && a_ram_wren) && n < 300) begin
            tick();
            n++;
        end
        n_total++;
        if (n >= 300) $display("FAIL rm_reach: %0d writes seen, want 3", aw_log.size());
        else n_pass++;
        a_rst = 1'b1;
        tick();
        n_total++;
        if ({a_busy, a_done, a_error, a_seg, a_rom_addr, a_rom_rd, a_ram_addr, a_ram_dout, a_ram_wren} !== '0)
            $display("FAIL rm_outputs: %h, want 0",
                     {a_busy, a_done, a_error, a_seg, a_rom_addr, a_rom_rd, a_ram_addr, a_ram_dout, a_ram_wren});
        else n_pass++;
        repeat (2) tick();
        clear_a(); model_a();
        a_rst = 1'b0;
        tick();
        n_total++;
        if (a_busy !== 1'b1) $display("FAIL rm_autorestart: busy %b, want 1", a_busy);
        else n_pass++;
        wait_a_idle(500, exp_to);
        n_total++;
        if (exp_to || a_done !== 1'b1) $display("FAIL rm_done: done %b expired %b, want 1 0", a_done, exp_to);
        else n_pass++;
        d = qdiff(aw_log, em_w);
        n_total++;
        if (d != -1) $display("FAIL rm_writes: diff at %0d (got %0d, want %0d)", d, aw_log.size(), em_w.size());
        else n_pass++;
        n_total++;
        if (a_seg_seq.size() != 3 || a_seg_seq[0] != 0 || a_viol != 0)
            $display("FAIL rm_seq: %0d segs first %0d viol %0d, want 3 0 0", a_seg_seq.size(),
                     a_seg_seq.size() > 0 ? a_seg_seq[0] : -1, a_viol);
        else n_pass++;
    endtask

    task automatic test_manual_start();
        int n = 0;
        int d;
        n_total++;
        if (b_busy !== 1'b0 || br_log.size() != 0 || b_done !== 1'b0)
            $display("FAIL man_idle: busy %b reads %0d done %b, want 0 0 0", b_busy, br_log.size(), b_done);
        else n_pass++;
        clear_b(); model_b();
        b_kmin = 1; b_kmax = 5;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        while (b_busy && n < 300) begin
            tick();
            n++;
        end
        n_total++;
        if (b_busy || b_done !== 1'b1) $display("FAIL man_done: busy %b done %b, want 0 1", b_busy, b_done);
        else n_pass++;
        d = qdiff(bw_log, em_w);
        n_total++;
        if (d != -1) $display("FAIL man_writes: diff at %0d (got %0d, want %0d)", d, bw_log.size(), em_w.size());
        else n_pass++;
        d = qdiff(br_log, em_r);
        n_total++;
        if (d != -1) $display("FAIL man_reads: diff at %0d (got %0d, want %0d)", d, br_log.size(), em_r.size());
        else n_pass++;
        n_total++;
        if (b_busy_cyc != 11 + b_ksum) $display("FAIL man_cycles: busy %0d cycles, want %0d", b_busy_cyc, 11 + b_ksum);
        else n_pass++;
        n_total++;
        if (b_viol != 0) $display("FAIL man_protocol: %0d violations, want 0", b_viol);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_auto_start();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_manual_start();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
